// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port IDs and read/write encoding.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LDST  = 1'b1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_LDST) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_rr_pick.sv
// Combinational two-way round-robin chooser: a lone requester wins outright,
// under contention the port that was not served last wins.
module mem_port_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = PORT_FETCH;
        if (req == 2'b11) begin
            winner = ~last_served;
        end else if (req[PORT_LDST]) begin
            winner = PORT_LDST;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch sequencer (port 0) and the
// load/store FSM (port 1). Define MEMARB_TIMEOUT_EN to add the MFC timeout and err output.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
`ifdef MEMARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 15
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        req_rw,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              MFC
`ifdef MEMARB_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    state_e            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_served_q, last_served_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic pick_winner;
    logic pick_valid;

`ifdef MEMARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign err         = err_q;
`endif

    mem_port_rr_pick u_pick (
        .req         (req),
        .last_served (last_served_q),
        .winner      (pick_winner),
        .valid       (pick_valid)
    );

    assign gnt       = gnt_q;
    assign rdata     = rdata_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_en    = (state_q == ACCESS);
    // last_served always names the current owner once a grant is made.
    assign done      = (state_q == RESP) ? port_onehot(last_served_q) : 2'b00;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_served_d = last_served_q;
        mem_rw_d      = mem_rw_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
`ifdef MEMARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d       = ACCESS;
                    gnt_d         = port_onehot(pick_winner);
                    last_served_d = pick_winner;
                    mem_rw_d      = req_rw[pick_winner];
                    mem_addr_d    = (pick_winner == PORT_LDST) ? req_addr1 : req_addr0;
                    mem_wdata_d   = (pick_winner == PORT_LDST) ? req_wdata1 : req_wdata0;
`ifdef MEMARB_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end
            end
            ACCESS: begin
`ifdef MEMARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (MFC) begin
                    state_d = RESP;
                    if (mem_rw_q == RW_READ) begin
                        rdata_d = mem_rdata;
                    end
`ifdef MEMARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
`endif
                end
            end
            RESP: begin
                // Clear the latched request so the port reads all-zero while idle.
                state_d     = IDLE;
                gnt_d       = 2'b00;
                mem_rw_d    = RW_WRITE;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
`ifdef MEMARB_TIMEOUT_EN
                err_d       = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= 2'b00;
            last_served_q <= PORT_LDST;
            mem_rw_q      <= RW_WRITE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
`ifdef MEMARB_TIMEOUT_EN
            cnt_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_served_q <= last_served_d;
            mem_rw_q      <= mem_rw_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
`ifdef MEMARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            err_q         <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the timeout steps are
// built only when MEMARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_rw;
    logic [15:0] req_addr0;
    logic [15:0] req_addr1;
    logic [15:0] req_wdata0;
    logic [15:0] req_wdata1;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [15:0] rdata;
    logic        mem_en;
    logic        mem_rw;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        MFC;
`ifdef MEMARB_TIMEOUT_EN
    logic        err;
`endif

    int checks;
    int errors;

    mem_port_arbiter #(
        .ADDR_W (16),
        .DATA_W (16)
`ifdef MEMARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (4)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_rw     (req_rw),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .gnt        (gnt),
        .done       (done),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .MFC        (MFC)
`ifdef MEMARB_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are checked 1 time unit after each rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] rw, input logic m);
        req    = r;
        req_rw = rw;
        MFC    = m;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Continuous guard: gnt and done must never be two-hot.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (gnt !== 2'b11 && done !== 2'b11)
            else begin
                errors++;
                $error("[TB] FAIL onehot: observed gnt=%b done=%b expected at most one bit each", gnt, done);
            end
        end
    end

    initial begin
        logic [1:0] exp_gnt;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        req_addr0  = 16'h0000;
        req_addr1  = 16'h0000;
        req_wdata0 = 16'h0000;
        req_wdata1 = 16'h0000;
        mem_rdata  = 16'h0000;
        applyStimulus(2'b00, 2'b00, 1'b0);
        tick();
        tick();
        $display("[TB] reset values");
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
        checkOutput("rst_mem_rw", 32'(mem_rw), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_rdata", 32'(rdata), 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("idle_gnt", 32'(gnt), 32'h0);

        $display("[TB] port 0 read, MFC on third ACCESS cycle");
        req_addr0 = 16'h0010;
        mem_rdata = 16'hBEEF;
        applyStimulus(2'b01, 2'b01, 1'b0);
        tick();
        checkOutput("rd_gnt", 32'(gnt), 32'h1);
        checkOutput("rd_mem_en1", 32'(mem_en), 32'h1);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'h0010);
        checkOutput("rd_mem_rw", 32'(mem_rw), 32'h1);
        checkOutput("rd_done_early", 32'(done), 32'h0);
        tick();
        checkOutput("rd_mem_en2", 32'(mem_en), 32'h1);
        tick();
        checkOutput("rd_mem_en3", 32'(mem_en), 32'h1);
        checkOutput("rd_done_wait", 32'(done), 32'h0);
        MFC = 1'b1;
        tick();
        checkOutput("rd_resp_en", 32'(mem_en), 32'h0);
        checkOutput("rd_done", 32'(done), 32'h1);
        checkOutput("rd_rdata", 32'(rdata), 32'hBEEF);
        checkOutput("rd_resp_gnt", 32'(gnt), 32'h1);
        applyStimulus(2'b00, 2'b00, 1'b0);
        tick();
        checkOutput("rd_idle_done", 32'(done), 32'h0);
        checkOutput("rd_idle_gnt", 32'(gnt), 32'h0);
        checkOutput("rd_idle_addr", 32'(mem_addr), 32'h0);
        checkOutput("rd_held_rdata", 32'(rdata), 32'hBEEF);

        $display("[TB] port 1 write");
        req_addr1  = 16'h0004;
        req_wdata1 = 16'h1234;
        mem_rdata  = 16'hDEAD;
        applyStimulus(2'b10, 2'b00, 1'b0);
        tick();
        checkOutput("wr_gnt", 32'(gnt), 32'h2);
        checkOutput("wr_mem_rw", 32'(mem_rw), 32'h0);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'h0004);
        checkOutput("wr_wdata1", 32'(mem_wdata), 32'h1234);
        tick();
        checkOutput("wr_wdata2", 32'(mem_wdata), 32'h1234);
        checkOutput("wr_mem_en", 32'(mem_en), 32'h1);
        MFC = 1'b1;
        tick();
        checkOutput("wr_done", 32'(done), 32'h2);
        checkOutput("wr_rdata_held", 32'(rdata), 32'hBEEF);
        applyStimulus(2'b00, 2'b00, 1'b0);
        tick();
        checkOutput("wr_idle_done", 32'(done), 32'h0);

        $display("[TB] continuous contention, immediate MFC");
        req_addr0 = 16'h0100;
        req_addr1 = 16'h0200;
        applyStimulus(2'b11, 2'b11, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_gnt   = (i % 2 == 0) ? 2'b01 : 2'b10;
            mem_rdata = 16'hA000 + 16'(i);
            tick();
            checkOutput($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(exp_gnt));
            checkOutput($sformatf("rr_addr%0d", i), 32'(mem_addr), (i % 2 == 0) ? 32'h0100 : 32'h0200);
            checkOutput($sformatf("rr_nodone%0d", i), 32'(done), 32'h0);
            tick();
            checkOutput($sformatf("rr_done%0d", i), 32'(done), 32'(exp_gnt));
            checkOutput($sformatf("rr_rdata%0d", i), 32'(rdata), 32'hA000 + 32'(i));
            tick();
            checkOutput($sformatf("rr_idle%0d", i), 32'({gnt, done}), 32'h0);
        end
        applyStimulus(2'b00, 2'b00, 1'b0);
        tick();

        $display("[TB] port 0 drops req during ACCESS");
        mem_rdata = 16'h5555;
        applyStimulus(2'b01, 2'b01, 1'b0);
        tick();
        checkOutput("drop_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        tick();
        checkOutput("drop_still_en", 32'(mem_en), 32'h1);
        MFC = 1'b1;
        tick();
        checkOutput("drop_done", 32'(done), 32'h1);
        checkOutput("drop_rdata", 32'(rdata), 32'h5555);
        MFC = 1'b0;
        tick();
        checkOutput("drop_idle", 32'({gnt, done, mem_en}), 32'h0);

        $display("[TB] reset during ACCESS");
        applyStimulus(2'b10, 2'b11, 1'b0);
        tick();
        checkOutput("mrst_gnt", 32'(gnt), 32'h2);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("mrst_en", 32'(mem_en), 32'h0);
        checkOutput("mrst_gnt0", 32'(gnt), 32'h0);
        checkOutput("mrst_done", 32'(done), 32'h0);
        checkOutput("mrst_rdata", 32'(rdata), 32'h0);
        rst = 1'b0;
        applyStimulus(2'b11, 2'b11, 1'b0);
        tick();
        checkOutput("mrst_first_gnt", 32'(gnt), 32'h1);
        mem_rdata = 16'h0F0F;
        MFC = 1'b1;
        tick();
        checkOutput("mrst_first_done", 32'(done), 32'h1);
        applyStimulus(2'b00, 2'b00, 1'b0);
        tick();

`ifdef MEMARB_TIMEOUT_EN
        $display("[TB] timeout with MFC never asserted");
        mem_rdata = 16'hFFFF;
        applyStimulus(2'b01, 2'b01, 1'b0);
        tick();
        checkOutput("to_gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("to_wait%0d", i), 32'({mem_en, err, done}), 32'h8);
        end
        tick();
        checkOutput("to_done", 32'(done), 32'h1);
        checkOutput("to_err", 32'(err), 32'h1);
        checkOutput("to_rdata", 32'(rdata), 32'h0);
        req = 2'b00;
        tick();
        checkOutput("to_err_clear", 32'(err), 32'h0);

        $display("[TB] MFC on the timeout cycle");
        mem_rdata = 16'h7777;
        applyStimulus(2'b01, 2'b01, 1'b0);
        tick();
        tick();
        tick();
        tick();
        MFC = 1'b1;
        tick();
        checkOutput("tomfc_done", 32'(done), 32'h1);
        checkOutput("tomfc_err", 32'(err), 32'h0);
        checkOutput("tomfc_rdata", 32'(rdata), 32'h7777);
        applyStimulus(2'b00, 2'b00, 1'b0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (enable / read-write / address / data, completion signalled by MFC) between two requesters.
- Port 0 is the instruction-fetch sequencer; port 1 is the load/store memory FSM.
- Round-robin arbitration; one transaction in flight at a time.
- Requesters see a req/done handshake instead of driving memory directly.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- TIMEOUT_CYC, 15, maximum access cycles waiting for MFC (used only with the optional feature); must be ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-port request; held high until that port's done.
- req_rw  in  2  per-port direction, 1=read, 0=write.
- req_addr0 / req_addr1  in  ADDR_W  per-port address.
- req_wdata0 / req_wdata1  in  DATA_W  per-port write data.
- gnt  out  2  one-hot; owner of the memory port.
- done  out  2  one-cycle completion pulse per port.
- rdata  out  DATA_W  read data; valid while done is high.
- mem_en  out  1  memory enable.
- mem_rw  out  1  1=read, 0=write.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data.
- MFC  in  1  memory function complete.
- err  out  1  timeout flag; present only with MEMARB_TIMEOUT_EN.

Behaviour:
- Reset (synchronous; also mid-transaction):
  - State goes to IDLE.
  - gnt, done, mem_en, mem_rw, err = 0; mem_addr, mem_wdata, rdata = 0.
  - last_served = 1, so port 0 wins the first contention.
  - Any in-flight transaction is dropped with no done pulse.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - With no req, stay in IDLE; all outputs 0 except held rdata.
  - If any req bit is set, pick the winner:
    - only one requester → it wins;
    - both → the port != last_served wins.
  - On that edge:
    - latch the winner's addr/wdata/rw into mem_addr/mem_wdata/mem_rw;
    - set gnt[winner] and last_served = winner;
    - go to ACCESS.
  - Grant latency is 1 cycle after req is seen.
- ACCESS:
  - mem_en = 1; gnt held; mem_* stable.
  - When MFC = 1 on a clock edge:
    - if mem_rw = 1, capture mem_rdata into rdata; for writes, rdata is held;
    - go to RESP.
  - MFC sampled in IDLE or RESP is ignored.
- RESP:
  - mem_en = 0; done[winner] = 1 for exactly this cycle; gnt still held.
  - Next edge: gnt = 0, go to IDLE.
  - A requester must drop req in the cycle after done, or it is treated as a new request.
  - Earliest re-grant to the same port is 2 cycles after done when the other port is idle.
- req deasserted during ACCESS: ignored; the transaction completes and done still pulses.
- Minimum transaction is 3 cycles (grant edge, ACCESS with MFC already high, RESP).
- Back-to-back contention alternates strictly 0,1,0,1.
- gnt and done are never high for both ports at once.

Optional Feature:
- Macro: MEMARB_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If it reaches TIMEOUT_CYC without MFC, go to RESP with err = 1 (alongside done) and rdata = 0.
  - err clears when RESP exits or on reset.
  - MFC arriving on the same edge as the timeout wins: normal completion, err = 0.
- Without the macro:
  - No counter and no err port.
  - ACCESS waits for MFC indefinitely.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10);
  - port ID constants PORT_FETCH=0, PORT_LDST=1;
  - RW encoding constants RW_READ=1, RW_WRITE=0.
- One sub-module, mem_port_rr_pick:
  - combinational 2-way round-robin chooser;
  - inputs req[1:0] and last_served; outputs winner and valid.
- The FSM, latches and timeout live in the top module.

Test Plan:
- Reset then req=2'b01, read, addr 0x0010; memory returns 0xBEEF with MFC 3 cycles into ACCESS → gnt=01, mem_en high 3 cycles, done[0] pulse one cycle with rdata=0xBEEF.
- req=2'b11 held continuously, MFC immediate, both reads → grant order 0,1,0,1; each done is single-cycle; gnt is never 11.
- Port 1 write: addr 0x0004, wdata 0x1234, mem_rw=0; MFC after 2 cycles → mem_wdata=0x1234 stable throughout ACCESS; done[1] pulse; rdata unchanged.
- Assert rst during ACCESS → next cycle mem_en=0, gnt=0; no done pulse; first grant after reset goes to port 0 under contention.
- Port 0 drops req mid-ACCESS, then MFC → done[0] still pulses; FSM returns to IDLE.
- With MEMARB_TIMEOUT_EN, TIMEOUT_CYC=4, MFC never asserted → after 4 ACCESS cycles, done and err high for one cycle with rdata=0; repeat with MFC on the 4th cycle → err=0.
